crc8_frame_tx: RTL and testbench

Transmit framer that sits directly upstream of the crc8 block. It buffers one payload frame from a byte stream and drives crc8's init and update inputs with each accepted payload byte. It then emits the frame as SOF, LEN, payload and a trailing CRC byte, taking the CRC byte from crc8's crc_out. Output is a valid/ready byte stream toward the serializer/UART stage.

---
 rtl/crc8_frame_tx.sv | 180 ++++++++++++++++++
 tb/tb_crc8_frame_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_tx.sv
//==============================================================================
// Module   : crc8_frame_tx
// Brief    : Transmit framer upstream of crc8. Buffers one payload frame and
//            emits SOF, LEN, payload, CRC on a valid/ready byte stream.
//            Optional statistics counters enabled by macro FRAMER_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module crc8_frame_tx #(
    parameter int          MAX_LEN  = 16,
    parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [7:0]  crc_data,
    output logic        crc_valid,
    output logic        crc_init,
    input  logic [7:0]  crc_value,
`ifdef FRAMER_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [7:0]  drop_cnt,
`endif
    output logic        err_overflow
);

    localparam int c_cnt_w  = $clog2(MAX_LEN + 1);
    localparam int c_addr_w = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_LEN);
    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_DROP      = 3'd2,
        ST_SEND_SOF  = 3'd3,
        ST_SEND_LEN  = 3'd4,
        ST_SEND_DATA = 3'd5,
        ST_SEND_CRC  = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   r_rd;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_crc_init;
    logic                 r_err_overflow;
    logic [7:0]           r_buf [0:MAX_LEN-1];

    logic                 w_accept;
    logic                 w_room;
    logic                 w_store;
    logic                 w_ovf;
    logic                 w_out_fire;
    logic                 w_data_end;
    logic [7:0]           w_len_byte;
    logic [7:0]           w_out_data;

    assign w_accept   = in_valid & r_in_ready;
    assign w_room     = (r_count < c_max);
    assign w_store    = w_accept & (r_state == ST_COLLECT) & w_room;
    assign w_ovf      = w_accept & (r_state == ST_COLLECT) & ~w_room;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_data_end = ((r_rd + c_one) == r_count);
    assign w_len_byte = 8'(r_count);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:      w_state_nxt = ST_COLLECT;
            ST_COLLECT: begin
                if (w_accept) begin
                    if (!w_room)
                        w_state_nxt = in_last ? ST_INIT : ST_DROP;
                    else if (in_last)
                        w_state_nxt = ST_SEND_SOF;
                end
            end
            ST_DROP:      if (w_accept && in_last) w_state_nxt = ST_INIT;
            ST_SEND_SOF:  if (w_out_fire) w_state_nxt = ST_SEND_LEN;
            ST_SEND_LEN:  if (w_out_fire) w_state_nxt = ST_SEND_DATA;
            ST_SEND_DATA: if (w_out_fire && w_data_end) w_state_nxt = ST_SEND_CRC;
            ST_SEND_CRC:  if (w_out_fire) w_state_nxt = ST_INIT;
            default:      w_state_nxt = ST_INIT;
        endcase
    end

    // Handshake flags are decoded from the next state so they leave the register directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_INIT;
            r_count        <= '0;
            r_rd           <= '0;
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_crc_init     <= 1'b1;
            r_err_overflow <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_in_ready     <= (w_state_nxt == ST_COLLECT) || (w_state_nxt == ST_DROP);
            r_out_valid    <= (w_state_nxt == ST_SEND_SOF) || (w_state_nxt == ST_SEND_LEN) ||
                              (w_state_nxt == ST_SEND_DATA) || (w_state_nxt == ST_SEND_CRC);
            r_out_last     <= (w_state_nxt == ST_SEND_CRC);
            r_crc_init     <= (w_state_nxt == ST_INIT);
            r_err_overflow <= w_ovf;

            if (r_state == ST_INIT)
                r_count <= '0;
            else if (w_store)
                r_count <= r_count + c_one;

            if (r_state == ST_INIT)
                r_rd <= '0;
            else if ((r_state == ST_SEND_DATA) && w_out_fire && !w_data_end)
                r_rd <= r_rd + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_store)
            r_buf[r_count[c_addr_w-1:0]] <= in_data;
    end

    // crc_value has settled by SEND_SOF and stays put, so it is forwarded unregistered.
    always_comb begin
        w_out_data = 8'h00;
        case (r_state)
            ST_SEND_SOF:  w_out_data = SOF_BYTE;
            ST_SEND_LEN:  w_out_data = w_len_byte;
            ST_SEND_DATA: w_out_data = r_buf[r_rd[c_addr_w-1:0]];
            ST_SEND_CRC:  w_out_data = crc_value;
            default:      w_out_data = 8'h00;
        endcase
    end

    assign in_ready     = r_in_ready;
    assign out_data     = w_out_data;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign crc_data     = in_data;
    assign crc_valid    = w_store;
    assign crc_init     = r_crc_init;
    assign err_overflow = r_err_overflow;

`ifdef FRAMER_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= 16'h0000;
            r_drop_cnt  <= 8'h00;
        end else begin
            if ((r_state == ST_SEND_CRC) && w_out_fire)
                r_frame_cnt <= r_frame_cnt + 16'h0001;
            if (r_err_overflow && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc8_frame_tx.sv
//==============================================================================
// Module   : tb_crc8_frame_tx
// Brief    : Self-checking bench for crc8_frame_tx with a behavioural crc8.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_crc8_frame_tx;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SOF     = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [7:0]  crc_data;
    logic        crc_valid;
    logic        crc_init;
    logic [7:0]  crc_value;
    logic        err_overflow;
`ifdef FRAMER_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;
`endif

    always #5 clk = ~clk;

    crc8_frame_tx #(.MAX_LEN(MAX_LEN), .SOF_BYTE(SOF)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .crc_data     (crc_data),
        .crc_valid    (crc_valid),
        .crc_init     (crc_init),
        .crc_value    (crc_value),
`ifdef FRAMER_STATS_EN
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
`endif
        .err_overflow (err_overflow)
    );

    // CRC-8, poly 0x07, init 0x00; crc_init has priority over data_valid.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    logic [7:0] crc_q;
    always @(posedge clk or posedge reset) begin
        if (reset)          crc_q <= 8'h00;
        else if (crc_init)  crc_q <= 8'h00;
        else if (crc_valid) crc_q <= crc8_step(crc_q, crc_data);
    end
    assign crc_value = crc_q;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        int         len;
        logic [7:0] d [0:15];
        logic [7:0] crc;
    } vec_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    vec_t       vt [0:4];
    logic [7:0] fr [0:19];
    int         total = 0;
    int         bad   = 0;
    int         n_pop = 0;
    int         n_err = 0;
    int         n_crcv = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (err_overflow) n_err++;
        if (crc_valid)    n_crcv++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 16'(exp_q.size()), 16'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 16'(out_data), 16'(mon_e.data));
                check("out_last", 16'(out_last), 16'(mon_e.last));
                n_pop++;
            end
        end
    end

    function automatic logic [7:0] crc_of(input int len);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < len; i++) c = crc8_step(c, fr[i]);
        return c;
    endfunction

    task automatic push_frame(input int len, input logic [7:0] crc);
        exp_q.push_back({SOF, 1'b0});
        exp_q.push_back({8'(len), 1'b0});
        for (int i = 0; i < len; i++) exp_q.push_back({fr[i], 1'b0});
        exp_q.push_back({crc, 1'b1});
    endtask

    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int len);
        for (int i = 0; i < len; i++) send_byte(fr[i], (i == len - 1));
    endtask

    task automatic drain(input bit bp);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(posedge clk); #1;
            if (bp) out_ready = 1'($urandom_range(0, 1));
            guard++;
        end
        out_ready = 1'b1;
        check("drain_left", 16'(exp_q.size()), 16'd0);
        check("crc_init_after_frame", 16'(crc_init), 16'd1);
        check("idle_out_valid", 16'(out_valid), 16'd0);
    endtask

    task automatic do_frame(input int len, input logic [7:0] crc, input bit bp);
        push_frame(len, crc);
        send_frame(len);
        check("sof_latency", {7'd0, out_valid, out_data}, {7'd0, 1'b1, SOF});
        drain(bp);
    endtask

    task automatic wait_pops(input int base, input int n);
        int guard;
        guard = 0;
        while ((n_pop - base) < n && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wait_pops", 16'(n_pop - base), 16'(n));
    endtask

    initial begin
        int base;
        int e0;
        int c0;

        vt[0].len = 1; vt[0].d[0] = 8'h01; vt[0].crc = 8'h07;
        vt[1].len = 2; vt[1].d[0] = 8'h01; vt[1].d[1] = 8'h02; vt[1].crc = 8'h1B;
        vt[2].len = 9; vt[2].crc = 8'hF4;
        for (int i = 0; i < 9; i++) vt[2].d[i] = 8'h31 + 8'(i);
        vt[3].len = 1; vt[3].d[0] = 8'hFF; vt[3].crc = 8'hF3;
        vt[4].len = 1; vt[4].d[0] = 8'h00; vt[4].crc = 8'h00;

        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b0;
        #2 reset  = 1'b1;
        #10;
        check("rst_in_ready",  16'(in_ready),     16'd0);
        check("rst_out_valid", 16'(out_valid),    16'd0);
        check("rst_out_last",  16'(out_last),     16'd0);
        check("rst_crc_valid", 16'(crc_valid),    16'd0);
        check("rst_crc_init",  16'(crc_init),     16'd1);
        check("rst_err",       16'(err_overflow), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_rst_init", 16'(crc_init), 16'd1);
        @(posedge clk); #1;
        check("collect_ready", {14'd0, in_ready, crc_init}, 16'b10);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) fr[i] = vt[v].d[i];
            do_frame(vt[v].len, vt[v].crc, 1'b0);
        end

        // Exactly MAX_LEN bytes is a legal frame.
        for (int i = 0; i < MAX_LEN; i++) fr[i] = 8'($urandom);
        do_frame(MAX_LEN, crc_of(MAX_LEN), 1'b1);

        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < len; i++) fr[i] = 8'($urandom);
            do_frame(len, crc_of(len), 1'b1);
        end

        // Output stall in SEND_DATA.
        for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
        push_frame(9, 8'hF4);
        base = n_pop;
        send_frame(9);
        wait_pops(base, 4);
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("stall_hold", {6'd0, in_ready, out_valid, out_data}, {6'd0, 1'b0, 1'b1, 8'h33});
        end
        out_ready = 1'b1;
        drain(1'b0);

        // Overflow: 20 bytes into a 16-byte buffer.
        for (int i = 0; i < 20; i++) fr[i] = 8'h40 + 8'(i);
        e0 = n_err;
        c0 = n_crcv;
        send_frame(20);
        check("ovf_to_init", {14'd0, crc_init, out_valid}, 16'b10);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_pulses", 16'(n_err - e0), 16'd1);
        check("ovf_crc_valids", 16'(n_crcv - c0), 16'(MAX_LEN));
        fr[0] = 8'h01;
        do_frame(1, 8'h07, 1'b0);

        // Async reset in the middle of SEND_DATA.
        for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
        push_frame(9, 8'hF4);
        base = n_pop;
        send_frame(9);
        wait_pops(base, 4);
        #2 reset = 1'b1;
        #1;
        check("async_rst", {13'd0, out_valid, crc_init, in_ready}, 16'b010);
        exp_q.delete();
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        check("rel_crc_init", 16'(crc_init), 16'd1);
        @(posedge clk); #1;
        check("rel_collect", {14'd0, in_ready, crc_init}, 16'b10);
        do_frame(9, 8'hF4, 1'b0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
